pc_range_capture: RTL and testbench
===================================

PC_RANGE_CAPTURE -- requirements
Module: pc_range_capture

Interface
REQ-001 SHALL have parameter RANGE_BINS, default 256, meaning range bins captured per pulse (power of two, 4..1024).
REQ-002 SHALL have parameter BIN_W, default log2(RANGE_BINS), meaning the width of the bin index.
REQ-003 SHALL have port clk  input  1  single clock; all logic is rising-edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port pulse_start  input  1  one-cycle strobe marking transmit-pulse start (PRI boundary).
REQ-006 SHALL have port data_valid_in  input  1  compressed-sample qualifier; no backpressure exists upstream.
REQ-007 SHALL have ports i_data_in, q_data_in  input  49 each  signed compressed I/Q samples.
REQ-008 SHALL have port m_axis_tvalid  output  1  magnitude stream valid.
REQ-009 SHALL have port m_axis_tready  input  1  downstream ready.
REQ-010 SHALL have port m_axis_tdata  output  50  unsigned magnitude |I|+|Q|.
REQ-011 SHALL have port m_axis_tlast  output  1  asserted with the last bin of a pulse.
REQ-012 SHALL have ports peak_valid  output  1, peak_bin  output  BIN_W, peak_mag  output  50  per-pulse peak report.
REQ-013 SHALL have port overrun  output  1  sticky flag: samples or pulse_start arrived while unable to accept.

Function
REQ-014 SHALL compute magnitude as |I|+|Q| in 50 unsigned bits; |-2^48| = 2^48 exactly, no saturation.
REQ-015 SHALL implement states IDLE, CAPTURE, DRAIN.
REQ-016 IDLE: data_valid_in ignored (no overrun); pulse_start -> CAPTURE next cycle, write index = 0, running peak cleared.
REQ-017 CAPTURE: each data_valid_in writes the magnitude to buffer[wr_idx] and increments wr_idx; pulse_start and data_valid_in in the same cycle as the IDLE->CAPTURE transition do not write that sample.
REQ-018 CAPTURE: the write at wr_idx = RANGE_BINS-1 -> DRAIN next cycle.
REQ-019 Peak tracking SHALL update only on strictly greater magnitude; ties keep the earliest bin; the first written sample always loads the peak.
REQ-020 peak_valid SHALL pulse for exactly one cycle, on the first DRAIN cycle; peak_bin/peak_mag are held from then until the next IDLE->CAPTURE transition.
REQ-021 DRAIN: SHALL stream buffer[0..RANGE_BINS-1] in order; m_axis_tvalid is high throughout DRAIN, with no bubbles while tready=1.
REQ-022 tdata/tlast SHALL remain stable while tvalid=1 and tready=0; a transfer occurs only on tvalid&tready.
REQ-023 tlast SHALL be 1 only on bin RANGE_BINS-1; after its transfer -> IDLE next cycle with tvalid=0.
REQ-024 pulse_start in CAPTURE or DRAIN, or data_valid_in in DRAIN, SHALL set overrun, SHALL be otherwise ignored, and SHALL NOT restart capture.
REQ-025 overrun SHALL clear only on reset.
REQ-026 Latency: first tvalid SHALL assert the cycle after the final CAPTURE write.

Reset
REQ-027 Reset assertion SHALL immediately force state IDLE, wr/rd indices 0, m_axis_tvalid=0, tlast=0, tdata=0, peak_valid=0, peak_bin=0, peak_mag=0, overrun=0.
REQ-028 Reset mid-CAPTURE or mid-DRAIN SHALL abandon the pulse; buffer contents need not be cleared.
REQ-029 After deassertion, the block SHALL wait in IDLE for pulse_start.

Verification (RANGE_BINS=4)
REQ-030 Nominal: pulse_start, then (I,Q) = (3,-4),(10,0),(-7,-7),(0,1), tready=1 -> tdata 7,10,14,1 on 4 consecutive cycles, tlast on 1; peak_bin=2, peak_mag=14, peak_valid one cycle.
REQ-031 Backpressure: same data, tready toggling 1,0,0,1,... -> identical sequence, tdata held during stalls, 4 transfers total.
REQ-032 Extremes: I=-2^48, Q=-2^48 -> tdata=2^49; tie values 5,5,2,1 -> peak_bin=0.
REQ-033 Overrun: pulse_start during CAPTURE, and data_valid_in during DRAIN -> overrun=1, output sequence unchanged, returns to IDLE.
REQ-034 Reset mid-DRAIN after 2 transfers -> tvalid=0 immediately; next pulse_start captures fresh data from bin 0.

Source files
------------

// File: rtl/pc_range_capture.sv
// Per-pulse range-bin capture: |I|+|Q| into a bin buffer, peak tracking, then
// an AXI-stream drain of the whole pulse with tlast on the final bin.
module pc_range_capture #(
  parameter int RANGE_BINS = 256,
  parameter int BIN_W      = $clog2(RANGE_BINS)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    pulse_start,
  input  logic                    data_valid_in,
  input  logic signed [48:0]      i_data_in,
  input  logic signed [48:0]      q_data_in,
  output logic                    m_axis_tvalid,
  input  logic                    m_axis_tready,
  output logic [49:0]             m_axis_tdata,
  output logic                    m_axis_tlast,
  output logic                    peak_valid,
  output logic [BIN_W-1:0]        peak_bin,
  output logic [49:0]             peak_mag,
  output logic                    overrun
);

  typedef enum logic [1:0] {IDLE, CAPTURE, DRAIN} state_t;

  state_t           r_state, w_state_nxt;
  logic [49:0]      r_mem [RANGE_BINS];
  logic [BIN_W-1:0] r_wr_idx, r_rd_idx, w_rd_nxt;
  logic [49:0]      r_tdata, r_peak_mag;
  logic [BIN_W-1:0] r_peak_bin;
  logic             r_tvalid, r_tlast, r_peak_valid, r_overrun;

  // Two's-complement negate in 49 unsigned bits maps -2^48 to 2^48 exactly.
  logic [48:0] w_abs_i, w_abs_q;
  logic [49:0] w_mag;
  assign w_abs_i = i_data_in[48] ? (~i_data_in + 49'd1) : i_data_in;
  assign w_abs_q = q_data_in[48] ? (~q_data_in + 49'd1) : q_data_in;
  assign w_mag   = {1'b0, w_abs_i} + {1'b0, w_abs_q};

  logic w_start, w_wr, w_last_wr, w_xfer, w_last_xfer, w_ovr;
  assign w_start     = (r_state == IDLE) && pulse_start;
  assign w_wr        = (r_state == CAPTURE) && data_valid_in;
  assign w_last_wr   = w_wr && (r_wr_idx == BIN_W'(RANGE_BINS-1));
  assign w_xfer      = r_tvalid && m_axis_tready;
  assign w_last_xfer = w_xfer && r_tlast;
  assign w_rd_nxt    = r_rd_idx + 1'b1;
  assign w_ovr       = (pulse_start && (r_state != IDLE)) ||
                       (data_valid_in && (r_state == DRAIN));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (pulse_start) w_state_nxt = CAPTURE;
      CAPTURE: if (w_last_wr)   w_state_nxt = DRAIN;
      DRAIN:   if (w_last_xfer) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Buffer is not reset; an abandoned pulse is simply overwritten.
  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wr_idx] <= w_mag;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_idx     <= '0;
      r_rd_idx     <= '0;
      r_tdata      <= '0;
      r_tvalid     <= 1'b0;
      r_tlast      <= 1'b0;
      r_peak_valid <= 1'b0;
      r_peak_bin   <= '0;
      r_peak_mag   <= '0;
      r_overrun    <= 1'b0;
    end else begin
      r_peak_valid <= 1'b0;
      if (w_ovr) r_overrun <= 1'b1;
      if (w_start) begin
        r_wr_idx   <= '0;
        r_peak_bin <= '0;
        r_peak_mag <= '0;
      end
      if (w_wr) begin
        r_wr_idx <= r_wr_idx + 1'b1;
        if ((r_wr_idx == '0) || (w_mag > r_peak_mag)) begin
          r_peak_bin <= r_wr_idx;
          r_peak_mag <= w_mag;
        end
      end
      // Bin 0 was written on an earlier cycle, so it can be preloaded here.
      if (w_last_wr) begin
        r_tvalid     <= 1'b1;
        r_tdata      <= r_mem[0];
        r_tlast      <= 1'b0;
        r_rd_idx     <= '0;
        r_peak_valid <= 1'b1;
      end
      if (w_xfer) begin
        if (r_tlast) begin
          r_tvalid <= 1'b0;
          r_tlast  <= 1'b0;
        end else begin
          r_rd_idx <= w_rd_nxt;
          r_tdata  <= r_mem[w_rd_nxt];
          r_tlast  <= (w_rd_nxt == BIN_W'(RANGE_BINS-1));
        end
      end
    end
  end

  assign m_axis_tvalid = r_tvalid;
  assign m_axis_tdata  = r_tdata;
  assign m_axis_tlast  = r_tlast;
  assign peak_valid    = r_peak_valid;
  assign peak_bin      = r_peak_bin;
  assign peak_mag      = r_peak_mag;
  assign overrun       = r_overrun;

endmodule

// File: tb/tb_pc_range_capture.sv
// Directed bench for pc_range_capture with RANGE_BINS=4: nominal, backpressure,
// extremes/ties, overrun and reset mid-drain, against hand-computed magnitudes.
module tb_pc_range_capture;
  localparam int N = 4;
  localparam int BW = 2;

  logic clk = 0, rst_n = 0, pulse_start = 0, data_valid_in = 0, m_axis_tready = 0;
  logic signed [48:0] i_data_in = '0, q_data_in = '0;
  logic m_axis_tvalid, m_axis_tlast, peak_valid, overrun;
  logic [49:0] m_axis_tdata, peak_mag;
  logic [BW-1:0] peak_bin;

  pc_range_capture #(.RANGE_BINS(N), .BIN_W(BW)) dut (
    .clk(clk), .rst_n(rst_n), .pulse_start(pulse_start), .data_valid_in(data_valid_in),
    .i_data_in(i_data_in), .q_data_in(q_data_in),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tlast(m_axis_tlast),
    .peak_valid(peak_valid), .peak_bin(peak_bin), .peak_mag(peak_mag), .overrun(overrun)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;
  logic signed [48:0] iv [N];
  logic signed [48:0] qv [N];
  logic [49:0] exp_mag [N];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic load(input int k, input logic signed [48:0] i, input logic signed [48:0] q,
                      input logic [49:0] m);
    iv[k] = i; qv[k] = q; exp_mag[k] = m;
  endtask

  task automatic start_and_fill(input bit ovr);
    pulse_start = 1; tick(); pulse_start = 0;
    for (int k = 0; k < N; k++) begin
      data_valid_in = 1; i_data_in = iv[k]; q_data_in = qv[k];
      pulse_start = ovr && (k == 1);
      tick();
      pulse_start = 0;
    end
    data_valid_in = 0;
  endtask

  task automatic drain(input bit bp, input bit ovr, input int exp_pbin, input logic [49:0] exp_pmag);
    int nx, pv_extra, gaps;
    nx = 0; pv_extra = 0; gaps = 0;
    chk("first_tvalid", m_axis_tvalid, 1);
    chk("peak_valid", peak_valid, 1);
    chk("peak_bin", peak_bin, exp_pbin);
    chk("peak_mag", peak_mag, exp_pmag);
    for (int c = 0; c < 40 && nx < N; c++) begin
      m_axis_tready = bp ? (c % 3 == 0) : 1'b1;
      data_valid_in = ovr && (c == 1);
      if (c > 0 && peak_valid) pv_extra++;
      if (!m_axis_tvalid) gaps++;
      else begin
        chk($sformatf("tdata[%0d]", nx), m_axis_tdata, exp_mag[nx]);
        chk($sformatf("tlast[%0d]", nx), m_axis_tlast, nx == N-1);
        if (m_axis_tready) nx++;
      end
      tick();
    end
    data_valid_in = 0; m_axis_tready = 0;
    chk("tvalid_gaps", gaps, 0);
    chk("pvalid_one_cycle", pv_extra, 0);
    chk("xfer_count", nx, N);
    chk("idle_tvalid", m_axis_tvalid, 0);
    chk("peak_bin_held", peak_bin, exp_pbin);
    chk("peak_mag_held", peak_mag, exp_pmag);
  endtask

  initial begin
    #12;
    chk("rst_tvalid", m_axis_tvalid, 0);
    chk("rst_tdata", m_axis_tdata, 0);
    chk("rst_peak", {peak_valid, peak_mag}, 0);
    chk("rst_overrun", overrun, 0);
    rst_n = 1; tick();

    // data_valid_in while IDLE is ignored
    data_valid_in = 1; i_data_in = 49'sd9; tick(); tick(); data_valid_in = 0;
    chk("idle_dv_overrun", overrun, 0);
    chk("idle_dv_tvalid", m_axis_tvalid, 0);

    load(0, 49'sd3, -49'sd4, 50'd7);   load(1, 49'sd10, 49'sd0, 50'd10);
    load(2, -49'sd7, -49'sd7, 50'd14); load(3, 49'sd0, 49'sd1, 50'd1);
    start_and_fill(0); drain(0, 0, 2, 50'd14);
    start_and_fill(0); drain(1, 0, 2, 50'd14);
    chk("no_overrun_yet", overrun, 0);

    load(0, 49'sh1_0000_0000_0000, 49'sh1_0000_0000_0000, 50'h2_0000_0000_0000);
    load(1, 49'sh0_FFFF_FFFF_FFFF, 49'sh0_FFFF_FFFF_FFFF, 50'h1_FFFF_FFFF_FFFE);
    load(2, 49'sd0, 49'sd0, 50'd0);    load(3, -49'sd1, 49'sd0, 50'd1);
    start_and_fill(0); drain(0, 0, 0, 50'h2_0000_0000_0000);

    load(0, 49'sd5, 49'sd0, 50'd5);    load(1, 49'sd0, -49'sd5, 50'd5);
    load(2, 49'sd2, 49'sd0, 50'd2);    load(3, 49'sd0, 49'sd1, 50'd1);
    start_and_fill(0); drain(0, 0, 0, 50'd5);

    load(0, 49'sd1, 49'sd0, 50'd1);    load(1, 49'sd2, 49'sd3, 50'd5);
    load(2, -49'sd5, 49'sd0, 50'd5);   load(3, 49'sd2, 49'sd0, 50'd2);
    start_and_fill(0); drain(0, 0, 1, 50'd5);

    // overrun: pulse_start mid-capture and data_valid_in mid-drain
    load(0, 49'sd3, -49'sd4, 50'd7);   load(1, 49'sd10, 49'sd0, 50'd10);
    load(2, -49'sd7, -49'sd7, 50'd14); load(3, 49'sd0, 49'sd1, 50'd1);
    start_and_fill(1); drain(1, 1, 2, 50'd14);
    chk("overrun_set", overrun, 1);
    tick(); tick();
    chk("overrun_sticky", overrun, 1);

    // reset after two drain transfers
    start_and_fill(0);
    m_axis_tready = 1; tick(); tick();
    chk("pre_rst_tvalid", m_axis_tvalid, 1);
    rst_n = 0; #1;
    chk("mid_rst_tvalid", m_axis_tvalid, 0);
    chk("mid_rst_tdata", m_axis_tdata, 0);
    chk("mid_rst_overrun", overrun, 0);
    chk("mid_rst_peak", {peak_valid, peak_bin, peak_mag}, 0);
    m_axis_tready = 0; #2; rst_n = 1; tick(); tick();
    chk("post_rst_idle", m_axis_tvalid, 0);
    load(0, 49'sd1, 49'sd1, 50'd2);    load(1, 49'sd2, -49'sd2, 50'd4);
    load(2, -49'sd3, 49'sd3, 50'd6);   load(3, 49'sd4, -49'sd4, 50'd8);
    start_and_fill(0); drain(0, 0, 3, 50'd8);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end
endmodule
